// File: rtl/stream_dwc_pkg.sv
// Shared constants and helpers for the stream width packer.
package stream_dwc_pkg;
  localparam int RATIO_MIN = 2;
  localparam int RATIO_MAX = 16;
  localparam logic PAD_BIT = 1'b0;

  function automatic int lane_w(input int ratio);
    return ($clog2(ratio) < 1) ? 1 : $clog2(ratio);
  endfunction
endpackage

// File: rtl/stream_dwc_pack_if.sv
// AXI-stream style valid/ready channel; master drives data/valid, slave drives ready.
interface stream_dwc_pack_if #(parameter int W = 8);
  logic [W-1:0] TDATA;
  logic         TVALID;
  logic         TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/stream_dwc_pack_out_reg.sv
// Single-slot output register; 1-cycle latency, accepts a load whenever empty or draining.
module stream_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_dat,
  output logic         o_free,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_dat
);
  logic         r_vld;
  logic [W-1:0] r_dat;

  assign o_free = !r_vld || i_rdy;
  assign o_vld  = r_vld;
  assign o_dat  = r_dat;

  // Callers only load when o_free, so a load always overwrites a drained slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_dwc_pack.sv
// Packs RATIO IN_W-bit beats little-endian into one word, 1 cycle after the last beat; input stalls
// only at the final lane while a word is held. STREAM_DWC_FLUSH_EN adds flush/TLAST for partial words.
module stream_dwc_pack
  import stream_dwc_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  stream_dwc_pack_if.slave         in0_V_V,
  stream_dwc_pack_if.master        out_V_V,
`ifdef STREAM_DWC_FLUSH_EN
  input  logic                     flush,
  output logic                     out_V_V_TLAST,
`endif
  output logic [lane_w(RATIO)-1:0] lane
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int LW    = lane_w(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
`ifdef STREAM_DWC_FLUSH_EN
  localparam int SLOT_W = OUT_W + 1;
`else
  localparam int SLOT_W = OUT_W;
`endif

  if (RATIO < RATIO_MIN || RATIO > RATIO_MAX) begin : g_bad_ratio
    $error("stream_dwc_pack: RATIO out of range");
  end

  logic [LW-1:0]              r_lane;
  logic [RATIO-2:0][IN_W-1:0] r_acc;
  logic [RATIO-1:0][IN_W-1:0] w_word;
  logic [SLOT_W-1:0]          w_slot_din;
  logic [SLOT_W-1:0]          w_slot_dout;
  logic w_free, w_in_rdy, w_in_hs, w_full, w_load, w_flush_fire;

`ifdef STREAM_DWC_FLUSH_EN
  assign w_in_rdy     = flush ? w_free : ((r_lane != LAST_LANE) || w_free);
  assign w_flush_fire = flush && w_free && ((r_lane != '0) || w_in_hs);
  assign w_slot_din   = {w_flush_fire, w_word};
  assign out_V_V_TLAST = w_slot_dout[OUT_W];
`else
  assign w_in_rdy     = (r_lane != LAST_LANE) || w_free;
  assign w_flush_fire = 1'b0;
  assign w_slot_din   = w_word;
`endif

  assign in0_V_V.TREADY = w_in_rdy;
  assign w_in_hs        = in0_V_V.TVALID && w_in_rdy;
  assign w_full         = w_in_hs && (r_lane == LAST_LANE);
  assign w_load         = w_full || w_flush_fire;
  assign lane           = r_lane;
  assign out_V_V.TDATA  = w_slot_dout[OUT_W-1:0];

  // Lanes not yet filled stay zero, so a flushed word is padded rather than carrying stale data.
  always_comb begin
    w_word = {OUT_W{PAD_BIT}};
    for (int k = 0; k < RATIO - 1; k++) begin
      if (k < int'(r_lane)) w_word[k] = r_acc[k];
    end
    for (int k = 0; k < RATIO; k++) begin
      if (w_in_hs && (k == int'(r_lane))) w_word[k] = in0_V_V.TDATA;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_lane <= '0;
      r_acc  <= '0;
    end else begin
      if (w_in_hs && (r_lane != LAST_LANE)) r_acc[r_lane] <= in0_V_V.TDATA;
      if (w_load)       r_lane <= '0;
      else if (w_in_hs) r_lane <= r_lane + LW'(1);
    end
  end

  stream_out_reg #(.W(SLOT_W)) u_out_reg (
    .clk    (ap_clk),
    .rst    (ap_rst),
    .i_load (w_load),
    .i_dat  (w_slot_din),
    .o_free (w_free),
    .o_vld  (out_V_V.TVALID),
    .i_rdy  (out_V_V.TREADY),
    .o_dat  (w_slot_dout)
  );
endmodule

// File: tb/tb_stream_dwc_pack.sv
// Bench for stream_dwc_pack: vector table, directed corner sequences, random traffic vs a beat-queue model.
module tb_stream_dwc_pack;
  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic       ap_clk = 1'b0;
  logic       ap_rst;
  logic       flush;
  logic [1:0] lane;
  logic       obs_last;

  stream_dwc_pack_if #(.W(IN_W))  in0_V_V ();
  stream_dwc_pack_if #(.W(OUT_W)) out_V_V ();

`ifdef STREAM_DWC_FLUSH_EN
  logic out_V_V_TLAST;
  assign obs_last = out_V_V_TLAST;
`else
  assign obs_last = 1'b0;
`endif

  stream_dwc_pack #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .in0_V_V (in0_V_V),
    .out_V_V (out_V_V),
`ifdef STREAM_DWC_FLUSH_EN
    .flush         (flush),
    .out_V_V_TLAST (out_V_V_TLAST),
`endif
    .lane    (lane)
  );

  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_words = 0;
  logic [OUT_W-1:0] last_word = '0;

  typedef struct {
    logic [OUT_W-1:0] dat;
    logic             last;
  } exp_t;
  exp_t exp_q[$];
  int   part[$];

  typedef struct {
    logic             in_vld;
    logic [IN_W-1:0]  in_dat;
    logic             out_rdy;
    logic             exp_ovld;
    logic [OUT_W-1:0] exp_odat;
    logic [1:0]       exp_lane;
    logic             exp_irdy;
  } vec_t;
  vec_t vec[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] pack_beats(input int beats[$]);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int k = 0; k < beats.size(); k++) w = w + (OUT_W'(beats[k]) << (IN_W * k));
    return w;
  endfunction

  // Reference model: accepted beats gathered in a queue, grouped RATIO at a time (or cut by flush).
  always @(negedge ap_clk) begin : mon
    logic slot_free;
    logic exp_irdy;
    if (ap_rst) begin
      exp_q.delete();
      part.delete();
    end else begin
      slot_free = !out_V_V.TVALID || out_V_V.TREADY;
      exp_irdy  = flush ? slot_free : ((part.size() < RATIO - 1) || slot_free);
      check("in_ready", 64'(in0_V_V.TREADY), 64'(exp_irdy));
      check("lane", 64'(lane), 64'(part.size()));
      check("out_valid", 64'(out_V_V.TVALID), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_data", 64'(out_V_V.TDATA), 64'(exp_q[0].dat));
        check("out_last", 64'(obs_last), 64'(exp_q[0].last));
        if (out_V_V.TVALID && out_V_V.TREADY) begin
          last_word = exp_q[0].dat;
          n_words++;
          void'(exp_q.pop_front());
        end
      end
      if (in0_V_V.TVALID && exp_irdy) part.push_back(int'(in0_V_V.TDATA));
      if (flush && slot_free && part.size() != 0) begin
        exp_q.push_back('{pack_beats(part), 1'b1});
        part.delete();
      end else if (part.size() == RATIO) begin
        exp_q.push_back('{pack_beats(part), 1'b0});
        part.delete();
      end
    end
  end

  task automatic drive(input logic vld, input logic [IN_W-1:0] dat, input logic rdy);
    @(posedge ap_clk);
    #1;
    in0_V_V.TVALID = vld;
    in0_V_V.TDATA  = dat;
    out_V_V.TREADY = rdy;
  endtask

  initial begin
    int w0;
    ap_rst = 1'b1;
    flush  = 1'b0;
    in0_V_V.TVALID = 1'b0;
    in0_V_V.TDATA  = '0;
    out_V_V.TREADY = 1'b0;

    vec[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1};
    vec[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 32'h0,        2'd1, 1'b1};
    vec[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 32'h0,        2'd2, 1'b1};
    vec[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 32'h0,        2'd3, 1'b1};
    vec[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 32'h44332211, 2'd0, 1'b1};
    vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1};
    vec[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1};
    vec[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 32'h0,        2'd1, 1'b1};
    vec[8]  = '{1'b1, 8'h03, 1'b0, 1'b0, 32'h0,        2'd2, 1'b1};
    vec[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 32'h0,        2'd3, 1'b1};
    vec[10] = '{1'b1, 8'h05, 1'b0, 1'b1, 32'h04030201, 2'd0, 1'b1};
    vec[11] = '{1'b1, 8'h06, 1'b0, 1'b1, 32'h04030201, 2'd1, 1'b1};
    vec[12] = '{1'b1, 8'h07, 1'b0, 1'b1, 32'h04030201, 2'd2, 1'b1};
    vec[13] = '{1'b1, 8'h08, 1'b0, 1'b1, 32'h04030201, 2'd3, 1'b0};
    vec[14] = '{1'b1, 8'h08, 1'b0, 1'b1, 32'h04030201, 2'd3, 1'b0};
    vec[15] = '{1'b1, 8'h08, 1'b1, 1'b1, 32'h04030201, 2'd3, 1'b1};
    vec[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 32'h08070605, 2'd0, 1'b1};
    vec[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1};

    #2;
    check("rst_lane", 64'(lane), 64'd0);
    check("rst_valid", 64'(out_V_V.TVALID), 64'd0);
    check("rst_data", 64'(out_V_V.TDATA), 64'd0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vec[i].in_vld, vec[i].in_dat, vec[i].out_rdy);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in0_V_V.TREADY), 64'(vec[i].exp_irdy));
      check($sformatf("vec%0d_lane", i), 64'(lane), 64'(vec[i].exp_lane));
      check($sformatf("vec%0d_out_valid", i), 64'(out_V_V.TVALID), 64'(vec[i].exp_ovld));
      if (vec[i].exp_ovld)
        check($sformatf("vec%0d_out_data", i), 64'(out_V_V.TDATA), 64'(vec[i].exp_odat));
    end

    // Full-rate stream: ready must never drop and four words emerge.
    w0 = n_words;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      #1 check("stream_in_ready", 64'(in0_V_V.TREADY), 64'd1);
    end
    repeat (3) drive(1'b0, 8'h00, 1'b1);
    check("stream_words", 64'(n_words - w0), 64'd4);
    check("stream_last_word", 64'(last_word), 64'h0F0E0D0C);

    // Reset with a stalled word pending and two lanes filled discards both.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("pre_rst_lane", 64'(lane), 64'd2);
    ap_rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_V_V.TVALID), 64'd0);
    check("mid_rst_lane", 64'(lane), 64'd0);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    w0 = n_words;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA1 + 8'(i), 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b1);
    check("post_rst_words", 64'(n_words - w0), 64'd1);
    check("post_rst_word", 64'(last_word), 64'hA4A3A2A1);

`ifdef STREAM_DWC_FLUSH_EN
    drive(1'b1, 8'h55, 1'b1);
    drive(1'b1, 8'h66, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    flush = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    #1;
    check("flush_valid", 64'(out_V_V.TVALID), 64'd1);
    check("flush_data", 64'(out_V_V.TDATA), 64'h00006655);
    check("flush_last", 64'(obs_last), 64'd1);
    drive(1'b0, 8'h00, 1'b1);
    #1 flush = 1'b0;
    check("flush_empty_valid", 64'(out_V_V.TVALID), 64'd0);
`endif

    w0 = n_words;
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(99) < 70), 8'($urandom), 1'($urandom_range(99) < 60));
`ifdef STREAM_DWC_FLUSH_EN
      flush = 1'($urandom_range(99) < 6);
`endif
    end
    flush = 1'b0;
    repeat (4) drive(1'b0, 8'h00, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("random_words_seen", 64'(n_words - w0 > 100), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
